// File: rtl/keypad_matrix_scanner_if.sv
// Key-event and matrix-line bundle between the keypad scanner and its consumer.
interface keypad_matrix_scanner_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_lost;

  modport master (
    input  col_in, key_ready,
    output row_out, key_state, key_valid, key_code, key_lost
  );

  modport slave (
    output col_in, key_ready,
    input  row_out, key_state, key_valid, key_code, key_lost
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: row-by-row scan, full-frame debounce and a buffered press-event queue.
module keypad_matrix_scanner #(
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  keypad_matrix_scanner_if.master kp
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic {DRIVE, SAMPLE} scan_state_t;

  scan_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          scan_on;
  logic [1:0]    row;
  logic [15:0]   frame, prev_frame, frame_done;
  logic [SW-1:0] stable, stable_next;
  logic [15:0]   key_state, pending, new_keys, clr_mask;
  logic          key_valid, key_lost, frame_end, accept, handshake;
  logic [3:0]    key_code, col_hit;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    sat_inc = (v == STABLE_MAX) ? STABLE_MAX : v + 1'b1;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    lowest_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_index = 4'(i);
    end
  endfunction

  // Scan sequencer: the slot counter only runs once a row is actually driven
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DRIVE;
      cnt     <= '0;
      scan_on <= 1'b0;
      row     <= 2'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      scan_on <= 1'b1;
      if (state == SAMPLE) row <= row + 2'd1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      DRIVE: begin
        if (scan_on) begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = SAMPLE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      SAMPLE:  state_next = DRIVE;
      default: state_next = DRIVE;
    endcase
  end

  assign col_hit    = ~kp.col_in;
  assign frame_done = {col_hit, frame[11:0]};
  assign frame_end  = (state == SAMPLE) && (row == 2'd3);
  assign stable_next = (frame_done == prev_frame) ? sat_inc(stable) : '0;
  assign accept     = frame_end && (stable_next == STABLE_MAX);
  assign new_keys   = accept ? (frame_done & ~key_state) : 16'd0;
  assign handshake  = key_valid & kp.key_ready;
  assign clr_mask   = handshake ? (16'd1 << key_code) : 16'd0;

  // Frame capture and debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      frame      <= '0;
      prev_frame <= '0;
      stable     <= '0;
      key_state  <= '0;
    end else if (state == SAMPLE) begin
      frame[{row, 2'b00} +: 4] <= col_hit;
      if (frame_end) begin
        prev_frame <= frame_done;
        stable     <= stable_next;
        if (accept) key_state <= frame_done;
      end
    end
  end

  // Event buffer: an accepted bit is cleared while same-cycle presses are kept
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_lost  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | new_keys;
      if (|(new_keys & pending & ~clr_mask)) key_lost <= 1'b1;
      if (handshake) begin
        key_valid <= 1'b0;
      end else if (!key_valid && (pending != 16'd0)) begin
        key_valid <= 1'b1;
        key_code  <= lowest_index(pending);
      end
    end
  end

  assign kp.row_out   = scan_on ? ~(4'b0001 << row) : 4'b1111;
  assign kp.key_state = key_state;
  assign kp.key_valid = key_valid;
  assign kp.key_code  = key_code;
  assign kp.key_lost  = key_lost;

endmodule
